// File: rtl/bus_mem_responder_pkg.sv
// rtl/bus_mem_responder_pkg.sv - shared constants and state encoding for the memory responder
package bus_mem_responder_pkg;

  localparam logic MODE_READ  = 1'b0;
  localparam logic MODE_WRITE = 1'b1;

  localparam int CNT_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/bus_mem_responder_if.sv
// rtl/bus_mem_responder_if.sv - ready/valid request bus between a master and the memory responder
interface bus_mem_responder_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  mode;
  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rvalid;
  logic                  err;

  modport master (
    output addr, wdata, mode, valid,
    input  ready, rdata, rvalid, err
  );

  modport slave (
    input  addr, wdata, mode, valid,
    output ready, rdata, rvalid, err
  );
endinterface

// File: rtl/bus_mem_array.sv
// rtl/bus_mem_array.sv - single-port word memory, synchronous write, combinational read, no reset
module bus_mem_array #(
  parameter int DEPTH      = 4096,
  parameter int DATA_WIDTH = 8,
  parameter int AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/bus_mem_responder.sv
// rtl/bus_mem_responder.sv - responder endpoint: one request at a time, LATENCY wait cycles, local memory
module bus_mem_responder
  import bus_mem_responder_pkg::*;
#(
  parameter int                   ADDR_WIDTH = 12,
  parameter int                   DATA_WIDTH = 8,
  parameter int                   MEM_DEPTH  = 4096,
  parameter int                   LATENCY    = 2,
  parameter logic [DATA_WIDTH-1:0] OOR_RDATA = 8'hFF
) (
  input  logic clk,
  input  logic rstn,
  bus_mem_responder_if.slave bus
);

  localparam int MEM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [CNT_W-1:0]    LAT_LOAD = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0]    CNT_ONE  = 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = MEM_DEPTH[ADDR_WIDTH:0];

  generate
    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
      $error("bus_mem_responder: LATENCY must be in 1..15");
    end
    if (MEM_DEPTH > (2 ** ADDR_WIDTH)) begin : g_bad_depth
      $error("bus_mem_responder: MEM_DEPTH exceeds address space");
    end
  endgenerate

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic [ADDR_WIDTH-1:0] cap_addr;
  logic [DATA_WIDTH-1:0] cap_wdata;
  logic                  cap_mode;
  logic                  ready_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  rvalid_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] mem_rd;
  logic                  in_range;
  logic                  done;
  logic                  mem_we;

  assign in_range = ({1'b0, cap_addr} < DEPTH_LIM);
  assign done     = (state == BUSY) && (cnt == '0);
  assign mem_we   = done && (cap_mode == MODE_WRITE) && in_range;

  bus_mem_array #(
    .DEPTH      (MEM_DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .AW         (MEM_AW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .addr  (cap_addr[MEM_AW-1:0]),
    .wdata (cap_wdata),
    .rdata (mem_rd)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      cnt       <= '0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      cap_mode  <= MODE_READ;
      ready_q   <= 1'b1;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.valid) begin
            cap_addr  <= bus.addr;
            cap_wdata <= bus.wdata;
            cap_mode  <= bus.mode;
            cnt       <= LAT_LOAD;
            ready_q   <= 1'b0;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_ONE;
          end else begin
            // Writes and write errors leave rdata untouched.
            if (cap_mode == MODE_READ) begin
              rdata_q  <= in_range ? mem_rd : OOR_RDATA;
              rvalid_q <= 1'b1;
            end
            err_q   <= !in_range;
            ready_q <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ready  = ready_q;
  assign bus.rdata  = rdata_q;
  assign bus.rvalid = rvalid_q;
  assign bus.err    = err_q;

endmodule

// File: tb/tb_bus_mem_responder.sv
// tb/tb_bus_mem_responder.sv - self-checking bench for bus_mem_responder with a transaction-level model
module tb_bus_mem_responder;

  localparam int MAIN_LAT   = 2;
  localparam int MAIN_DEPTH = 2048;

  logic clk;
  logic rstn;
  int   checks;
  int   errors;

  bus_mem_responder_if #(.ADDR_WIDTH(12), .DATA_WIDTH(8)) bus_m ();
  bus_mem_responder_if #(.ADDR_WIDTH(12), .DATA_WIDTH(8)) sw1 ();
  bus_mem_responder_if #(.ADDR_WIDTH(12), .DATA_WIDTH(8)) sw7 ();
  bus_mem_responder_if #(.ADDR_WIDTH(12), .DATA_WIDTH(8)) sw15 ();

  bus_mem_responder #(.ADDR_WIDTH(12), .DATA_WIDTH(8), .MEM_DEPTH(MAIN_DEPTH),
                      .LATENCY(MAIN_LAT), .OOR_RDATA(8'hFF))
    dut (.clk(clk), .rstn(rstn), .bus(bus_m));
  bus_mem_responder #(.LATENCY(1))  dut_l1  (.clk(clk), .rstn(rstn), .bus(sw1));
  bus_mem_responder #(.LATENCY(7))  dut_l7  (.clk(clk), .rstn(rstn), .bus(sw7));
  bus_mem_responder #(.LATENCY(15)) dut_l15 (.clk(clk), .rstn(rstn), .bus(sw15));

  logic [11:0] s_addr;
  logic [7:0]  s_wdata;
  logic        s_mode;
  logic        s_valid;
  assign sw1.addr  = s_addr;  assign sw1.wdata  = s_wdata; assign sw1.mode  = s_mode; assign sw1.valid  = s_valid;
  assign sw7.addr  = s_addr;  assign sw7.wdata  = s_wdata; assign sw7.mode  = s_mode; assign sw7.valid  = s_valid;
  assign sw15.addr = s_addr;  assign sw15.wdata = s_wdata; assign sw15.mode = s_mode; assign sw15.valid = s_valid;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Transaction-level model: an accepted request finishes LATENCY edges later.
  logic [7:0]  mm [int];
  int          cyc;
  bit          m_busy;
  int          m_done_at;
  logic [11:0] m_addr;
  logic [7:0]  m_wdata;
  logic        m_mode;
  logic        e_ready;
  logic [7:0]  e_rdata;
  bit          e_rdata_known;
  logic        e_rvalid;
  logic        e_err;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_busy = 0; e_ready = 1'b1; e_rdata = 8'h00; e_rdata_known = 1;
      e_rvalid = 1'b0; e_err = 1'b0;
    end else begin
      cyc++;
      e_rvalid = 1'b0;
      e_err    = 1'b0;
      if (m_busy && cyc == m_done_at) begin
        if (int'(m_addr) < MAIN_DEPTH) begin
          if (m_mode) mm[int'(m_addr)] = m_wdata;
          else begin
            e_rvalid = 1'b1;
            e_rdata_known = mm.exists(int'(m_addr));
            if (e_rdata_known) e_rdata = mm[int'(m_addr)];
          end
        end else begin
          e_err = 1'b1;
          if (!m_mode) begin e_rvalid = 1'b1; e_rdata = 8'hFF; e_rdata_known = 1; end
        end
        m_busy  = 0;
        e_ready = 1'b1;
      end else if (!m_busy && bus_m.valid) begin
        m_busy = 1; m_done_at = cyc + MAIN_LAT;
        m_addr = bus_m.addr; m_wdata = bus_m.wdata; m_mode = bus_m.mode;
        e_ready = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    check("ready", {31'd0, bus_m.ready}, {31'd0, e_ready});
    check("rvalid", {31'd0, bus_m.rvalid}, {31'd0, e_rvalid});
    check("err", {31'd0, bus_m.err}, {31'd0, e_err});
    if (e_rdata_known) check("rdata", {24'd0, bus_m.rdata}, {24'd0, e_rdata});
  end

  task automatic issue(input logic m, input logic [11:0] a, input logic [7:0] d,
                       output int low, output int rv, output int er);
    @(negedge clk);
    bus_m.mode = m; bus_m.addr = a; bus_m.wdata = d; bus_m.valid = 1'b1;
    @(negedge clk);
    bus_m.valid = 1'b0;
    low = 0; rv = 0; er = 0;
    for (int i = 0; i < 6; i++) begin
      low += int'(!bus_m.ready);
      rv  += int'(bus_m.rvalid);
      er  += int'(bus_m.err);
      @(negedge clk);
    end
  endtask

  int low, rv, er;
  int low1, low7, low15, rv1, rv7, rv15;

  initial begin
    checks = 0; errors = 0; cyc = 0;
    m_busy = 0; e_ready = 1'b1; e_rdata = 8'h00; e_rdata_known = 1;
    e_rvalid = 1'b0; e_err = 1'b0;
    bus_m.addr = '0; bus_m.wdata = '0; bus_m.mode = 1'b0; bus_m.valid = 1'b0;
    s_addr = '0; s_wdata = '0; s_mode = 1'b0; s_valid = 1'b0;
    rstn = 1'b0;
    #15 rstn = 1'b1;
    repeat (10) @(negedge clk);
    check("reset_ready", {31'd0, bus_m.ready}, 32'd1);
    check("reset_rdata", {24'd0, bus_m.rdata}, 32'h00);

    issue(1'b1, 12'h020, 8'h11, low, rv, er);
    issue(1'b1, 12'h040, 8'h22, low, rv, er);
    issue(1'b1, 12'h100, 8'h33, low, rv, er);
    issue(1'b1, 12'h123, 8'hA5, low, rv, er);
    check("wr_ready_low", low, 32'd2);
    check("wr_no_rvalid", rv, 32'd0);
    issue(1'b0, 12'h123, 8'h00, low, rv, er);
    check("rd_ready_low", low, 32'd2);
    check("rd_rvalid_pulse", rv, 32'd1);
    check("rd_data_a5", {24'd0, bus_m.rdata}, 32'hA5);

    // Inputs change while busy; valid stays up so a second write follows.
    @(negedge clk);
    bus_m.mode = 1'b1; bus_m.addr = 12'h010; bus_m.wdata = 8'h3C; bus_m.valid = 1'b1;
    @(negedge clk);
    bus_m.addr = 12'h020; bus_m.wdata = 8'hFF;
    repeat (3) @(negedge clk);
    bus_m.valid = 1'b0;
    repeat (4) @(negedge clk);
    issue(1'b0, 12'h010, 8'h00, low, rv, er);
    check("busy_ignore_010", {24'd0, bus_m.rdata}, 32'h3C);
    issue(1'b0, 12'h020, 8'h00, low, rv, er);
    check("repeat_write_020", {24'd0, bus_m.rdata}, 32'hFF);

    issue(1'b1, 12'h900, 8'h55, low, rv, er);
    check("oor_wr_err", er, 32'd1);
    check("oor_wr_rvalid", rv, 32'd0);
    check("oor_wr_rdata_held", {24'd0, bus_m.rdata}, 32'hFF);
    issue(1'b0, 12'h100, 8'h00, low, rv, er);
    check("oor_no_alias", {24'd0, bus_m.rdata}, 32'h33);
    issue(1'b0, 12'h900, 8'h00, low, rv, er);
    check("oor_rd_rdata", {24'd0, bus_m.rdata}, 32'hFF);
    check("oor_rd_rvalid", rv, 32'd1);
    check("oor_rd_err", er, 32'd1);

    // Latency sweep on three instances driven in lockstep.
    @(negedge clk);
    s_mode = 1'b1; s_addr = 12'h011; s_wdata = 8'h5A; s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    repeat (20) @(negedge clk);
    s_mode = 1'b0; s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    low1 = 0; low7 = 0; low15 = 0; rv1 = 0; rv7 = 0; rv15 = 0;
    for (int i = 0; i < 20; i++) begin
      low1 += int'(!sw1.ready); low7 += int'(!sw7.ready); low15 += int'(!sw15.ready);
      rv1 += int'(sw1.rvalid);  rv7 += int'(sw7.rvalid);  rv15 += int'(sw15.rvalid);
      @(negedge clk);
    end
    check("lat1_low", low1, 32'd1);
    check("lat7_low", low7, 32'd7);
    check("lat15_low", low15, 32'd15);
    check("lat1_rvalid", rv1, 32'd1);
    check("lat7_rvalid", rv7, 32'd1);
    check("lat15_rvalid", rv15, 32'd1);
    check("lat1_rdata", {24'd0, sw1.rdata}, 32'h5A);
    check("lat7_rdata", {24'd0, sw7.rdata}, 32'h5A);
    check("lat15_rdata", {24'd0, sw15.rdata}, 32'h5A);

    // Reset lands while the write of 0x77 is still pending.
    @(negedge clk);
    bus_m.mode = 1'b1; bus_m.addr = 12'h040; bus_m.wdata = 8'h77; bus_m.valid = 1'b1;
    @(negedge clk);
    bus_m.valid = 1'b0;
    #2 rstn = 1'b0;
    #1;
    check("rst_mid_ready", {31'd0, bus_m.ready}, 32'd1);
    check("rst_mid_rdata", {24'd0, bus_m.rdata}, 32'h00);
    check("rst_mid_rvalid", {31'd0, bus_m.rvalid}, 32'd0);
    @(negedge clk);
    #2 rstn = 1'b1;
    repeat (2) @(negedge clk);
    issue(1'b0, 12'h040, 8'h00, low, rv, er);
    check("rst_mid_mem_kept", {24'd0, bus_m.rdata}, 32'h22);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
